// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: FSM state, legal LFSR widths and the polynomial
// taps, used by both the generator and the checker.
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int PRBS_W_MAX = 16;
  localparam int PRBS_W4    = 4;
  localparam int PRBS_W8    = 8;
  localparam int PRBS_W16   = 16;

  function automatic logic prbs_width_legal(input int width);
    return (width == PRBS_W4) || (width == PRBS_W8) || (width == PRBS_W16);
  endfunction

  // Feedback bit for a left-shifting register; sr is zero-extended to 16 bits.
  function automatic logic prbs_taps(input logic [PRBS_W_MAX-1:0] sr, input int width);
    logic fb;
    case (width)
      PRBS_W4:  fb = sr[3] ^ sr[2];
      PRBS_W8:  fb = sr[7] ^ sr[5] ^ sr[4] ^ sr[3];
      PRBS_W16: fb = sr[15] ^ sr[13] ^ sr[12] ^ sr[10];
      default:  fb = 1'b0;
    endcase
    return fb;
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronises on the incoming stream, then
// free-runs its own LFSR and counts bit errors, dropping lock on a burst.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_strb,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  if (!prbs_width_legal(WIDTH)) begin : g_bad_width
    $error("prbs_checker: WIDTH must be 4, 8 or 16");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_bad_lock
    $error("prbs_checker: LOCK_COUNT out of range 1..255");
  end
  if (LOSS_COUNT < 1 || LOSS_COUNT > 255) begin : g_bad_loss
    $error("prbs_checker: LOSS_COUNT out of range 1..255");
  end

  localparam logic [8:0] LOCK_N = 9'(LOCK_COUNT);
  localparam logic [8:0] LOSS_N = 9'(LOSS_COUNT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       miss_q, miss_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic             strb_q, strb_d;

  logic             expected, mismatch, good_pred;
  logic [8:0]       match_inc, miss_inc;
  logic             lock_hit, loss_hit;
  logic             err_ev, bit_ev;
  logic [CNT_W-1:0] err_base, bit_base;

  assign expected  = prbs_taps(PRBS_W_MAX'(sr_q), WIDTH);
  assign mismatch  = bit_in ^ expected;
  // A prediction from an all-zero register is meaningless (stuck-at-0 line).
  assign good_pred = (sr_q != '0) && !mismatch;
  assign match_inc = {1'b0, match_q} + 9'd1;
  assign miss_inc  = {1'b0, miss_q} + 9'd1;
  assign lock_hit  = (state_q == SEARCH) && good_pred && (match_inc == LOCK_N);
  assign loss_hit  = (state_q == LOCKED) && mismatch && (miss_inc == LOSS_N);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      case (state_q)
        SEARCH:  if (lock_hit) state_d = LOCKED;
        LOCKED:  if (loss_hit) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    locked = (state_q == LOCKED);
  end

  always_comb begin
    sr_d    = sr_q;
    match_d = match_q;
    miss_d  = miss_q;
    strb_d  = 1'b0;
    err_ev  = 1'b0;
    bit_ev  = 1'b0;
    if (bit_valid) begin
      case (state_q)
        SEARCH: begin
          sr_d    = {sr_q[WIDTH-2:0], bit_in};
          match_d = (good_pred && !lock_hit) ? match_inc[7:0] : 8'd0;
          if (lock_hit) miss_d = 8'd0;
        end
        LOCKED: begin
          // Free-run on our own prediction so line errors never corrupt sr.
          sr_d   = {sr_q[WIDTH-2:0], expected};
          bit_ev = 1'b1;
          if (mismatch) begin
            err_ev = 1'b1;
            strb_d = 1'b1;
            miss_d = loss_hit ? 8'd0 : miss_inc[7:0];
          end else begin
            miss_d = 8'd0;
          end
          if (loss_hit) match_d = 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Clear applies first so a coincident event still contributes one count.
  always_comb begin
    err_base = clear_cnt ? '0 : err_q;
    bit_base = clear_cnt ? '0 : bit_q;
    err_d    = err_base;
    bit_d    = bit_base;
    if (err_ev && (err_base != '1)) err_d = err_base + CNT_W'(1);
    if (bit_ev && (bit_base != '1)) bit_d = bit_base + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      bit_q   <= '0;
      strb_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      bit_q   <= bit_d;
      strb_q  <= strb_d;
    end
  end

  assign err_strb  = strb_q;
  assign err_count = err_q;
  assign bit_count = bit_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: W8 stream from a 0xFF-seeded generator,
// lock/error/loss/stuck/gap/clear/reset cases, plus a narrow-counter instance.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked, err_strb;
  logic [15:0] err_count, bit_count;
  logic        s_locked, s_strb;
  logic [3:0]  s_err, s_bit;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [7:0] gsr;

  always #5 clk = ~clk;

  prbs_checker #(.WIDTH(8), .LOCK_COUNT(16), .LOSS_COUNT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_cnt(clear_cnt), .locked(locked), .err_strb(err_strb),
    .err_count(err_count), .bit_count(bit_count)
  );

  // Narrow counters so saturation is reachable quickly.
  prbs_checker #(.WIDTH(8), .LOCK_COUNT(16), .LOSS_COUNT(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_cnt(clear_cnt), .locked(s_locked), .err_strb(s_strb),
    .err_count(s_err), .bit_count(s_bit)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference W8 generator: x^8+x^6+x^5+x^4 taps, output is the feedback bit.
  task automatic gen_next(output logic b);
    b   = gsr[7] ^ gsr[5] ^ gsr[4] ^ gsr[3];
    gsr = {gsr[6:0], b};
  endtask

  task automatic step(input logic b, input logic v, input logic clr, input logic r);
    @(negedge clk);
    bit_in = b; bit_valid = v; clear_cnt = clr; rst = r;
    @(posedge clk);
    #1;
    bit_valid = 1'b0; clear_cnt = 1'b0; rst = 1'b0;
  endtask

  task automatic send(input int n, input logic inv);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_next(b);
      step(b ^ inv, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic b;
    logic seen;
    int   vc;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);
    chk("rst_bit", bit_count, 0);
    chk("rst_strb", err_strb, 0);

    // Clean lock: first counted prediction is bit 6, bits 9..24 lock it.
    gsr = 8'hFF;
    send(23, 1'b0);
    chk("lock_pre24", locked, 0);
    send(1, 1'b0);
    chk("lock_at24", locked, 1);
    send(16, 1'b0);
    chk("clean_err", err_count, 0);
    chk("clean_bits", bit_count, 16);

    // Single error
    send(1, 1'b1);
    chk("single_strb", err_strb, 1);
    chk("single_err", err_count, 1);
    chk("single_lock", locked, 1);
    send(1, 1'b0);
    chk("single_strb_off", err_strb, 0);
    send(19, 1'b0);
    chk("single_err_hold", err_count, 1);
    chk("single_bits", bit_count, 37);
    chk("single_lock2", locked, 1);

    // Clear on an idle cycle, then a 4-error burst drops lock
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_err", err_count, 0);
    chk("clr_bit", bit_count, 0);
    send(3, 1'b1);
    chk("loss_3_lock", locked, 1);
    chk("loss_3_err", err_count, 3);
    send(1, 1'b1);
    chk("loss_4_lock", locked, 0);
    chk("loss_4_err", err_count, 4);
    // sr kept its free-running value, so every prediction is good again
    send(15, 1'b0);
    chk("relock_pre", locked, 0);
    send(1, 1'b0);
    chk("relock", locked, 1);
    chk("relock_err", err_count, 4);
    chk("relock_bits", bit_count, 4);
    send(3, 1'b0);

    // Reset mid-lock
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_lock", locked, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_bit", bit_count, 0);
    send(16, 1'b0);
    chk("rst_relock_pre", locked, 0);
    send(8, 1'b0);
    chk("rst_relock", locked, 1);

    // Clear coincident with a mismatch
    gen_next(b);
    step(~b, 1'b1, 1'b1, 1'b0);
    chk("clr_coinc_err", err_count, 1);
    chk("clr_coinc_strb", err_strb, 1);
    chk("sat_start", s_err, 1);

    // Saturation: isolated errors keep lock; narrow counters stop at 15
    for (int i = 0; i < 20; i++) begin
      send(1, 1'b1);
      send(1, 1'b0);
    end
    chk("sat_err", s_err, 15);
    chk("sat_bit", s_bit, 15);
    chk("sat_lock", s_locked, 1);
    chk("wide_err", err_count, 21);
    send(1, 1'b1);
    chk("sat_err_hold", s_err, 15);

    // Stuck line: 100 zeros then 100 ones never lock
    step(1'b0, 1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step((i >= 100), 1'b1, 1'b0, 1'b0);
      if (locked) seen = 1'b1;
    end
    chk("stuck_lock", seen, 0);
    chk("stuck_err", err_count, 0);
    chk("stuck_bits", bit_count, 0);

    // Gaps: lock point in valid bits matches the clean case
    step(1'b0, 1'b0, 1'b0, 1'b1);
    gsr = 8'hFF;
    vc  = 0;
    while (vc < 23) begin
      if ($urandom_range(0, 2) == 0) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      send(1, 1'b0);
      vc++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_pre24", locked, 0);
    send(1, 1'b0);
    chk("gap_at24", locked, 1);
    send(5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_idle_bits", bit_count, 5);
    chk("gap_idle_strb", err_strb, 0);
    send(1, 1'b0);
    chk("gap_resume_bits", bit_count, 6);
    chk("gap_err", err_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
